// File: rtl/req_scheduler.sv
// Elevator request scheduler: latches floor-button presses and issues one
// SCAN-ordered target floor at a time, with a hold-off after each door cycle.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no target; arbitrate as soon as any request is pending
// ISSUE | target held on Req until the door opens at that floor
// DWELL | door open at the served floor; wait for it to close
// HOLD  | post-door hold-off, counting HOLD_CYC cycles down
module req_scheduler #(
  parameter int HOLD_CYC = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic [3:1] Btn,
  input  logic       FLR1,
  input  logic       FLR2,
  input  logic       FLR3,
  input  logic       Door,
  output logic [3:1] Req,
  output logic [3:1] Pending,
  output logic       Dir,
  output logic       Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DWELL = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [1:0]       cur;
  logic [CNT_W-1:0] cnt;

  logic [3:1] flr_vec;
  logic [1:0] cur_nxt;
  logic [3:1] cur_oh;
  logic [3:1] clr;
  logic [3:1] up_mask;
  logic [3:1] dn_mask;
  logic [3:1] up_cand;
  logic [3:1] dn_cand;
  logic [3:1] arb_req;
  logic       arb_dir;

  function automatic logic [3:1] lowest(input logic [3:1] v);
    logic [3:1] r;
    r = 3'b000;
    if (v[1])      r = 3'b001;
    else if (v[2]) r = 3'b010;
    else if (v[3]) r = 3'b100;
    return r;
  endfunction

  function automatic logic [3:1] highest(input logic [3:1] v);
    logic [3:1] r;
    r = 3'b000;
    if (v[3])      r = 3'b100;
    else if (v[2]) r = 3'b010;
    else if (v[1]) r = 3'b001;
    return r;
  endfunction

  assign flr_vec = {FLR3, FLR2, FLR1};
  assign Busy    = (state != IDLE);

  // Floor position only moves on an unambiguous indicator
  always_comb begin
    cur_nxt = cur;
    case (flr_vec)
      3'b001:  cur_nxt = 2'd1;
      3'b010:  cur_nxt = 2'd2;
      3'b100:  cur_nxt = 2'd3;
      default: cur_nxt = cur;
    endcase
  end

  always_comb begin
    cur_oh  = 3'b001;
    up_mask = 3'b111;
    dn_mask = 3'b001;
    case (cur)
      2'd2: begin
        cur_oh  = 3'b010;
        up_mask = 3'b110;
        dn_mask = 3'b011;
      end
      2'd3: begin
        cur_oh  = 3'b100;
        up_mask = 3'b100;
        dn_mask = 3'b111;
      end
      default: begin
        cur_oh  = 3'b001;
        up_mask = 3'b111;
        dn_mask = 3'b001;
      end
    endcase
  end

  assign clr     = Door ? cur_oh : 3'b000;
  assign up_cand = Pending & up_mask;
  assign dn_cand = Pending & dn_mask;

  // Both candidate sets include cur, so a request at cur always wins
  always_comb begin
    arb_req = 3'b000;
    arb_dir = Dir;
    if (!Dir) begin
      if (up_cand != 3'b000) begin
        arb_req = lowest(up_cand);
        arb_dir = 1'b0;
      end else begin
        arb_req = highest(dn_cand);
        arb_dir = 1'b1;
      end
    end else begin
      if (dn_cand != 3'b000) begin
        arb_req = highest(dn_cand);
        arb_dir = 1'b1;
      end else begin
        arb_req = lowest(up_cand);
        arb_dir = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      Req     <= 3'b000;
      Pending <= 3'b000;
      Dir     <= 1'b0;
      cnt     <= '0;
      cur     <= 2'd1;
    end else begin
      Pending <= (Pending | Btn) & ~clr;
      cur     <= cur_nxt;
      case (state)
        IDLE: begin
          Req <= 3'b000;
          if (Pending != 3'b000) begin
            Req   <= arb_req;
            Dir   <= arb_dir;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (Door && (Req == cur_oh)) begin
            Req   <= 3'b000;
            state <= DWELL;
          end
        end
        DWELL: begin
          Req <= 3'b000;
          if (!Door) begin
            if (HOLD_CYC == 0) begin
              state <= IDLE;
            end else begin
              cnt   <= HOLD_LD;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          Req <= 3'b000;
          if (cnt <= CNT_ONE) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          Req   <= 3'b000;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
